n64_vtiming_analyzer: RTL and testbench

Front-end video timing analyzer on the N64 VCLK domain. Samples the sync nibble of the VD bus in every nVDSYNC phase and measures lines per field. Classifies the signal as PAL/NTSC and progressive/interlaced, and tracks the field ID. Its results feed the PPU state word that the controller/NIOS block resynchronises to CLK_50M.

---
 rtl/n64_vtiming_analyzer.sv | 191 +++++++++++++++++++
 tb/tb_n64_vtiming_analyzer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/n64_vtiming_analyzer.sv
// N64 video timing front end: samples the VD sync nibble on every nVDSYNC strobe,
// counts lines per field and classifies PAL/NTSC, progressive/interlaced and field ID.
module n64_vtiming_analyzer #(
  parameter logic [9:0]  PAL_LINE_THRES = 10'd288,
  parameter logic [11:0] H_TIMEOUT      = 12'd4095
) (
  input  logic       VCLK,
  input  logic       nVRST,
  input  logic       nVDSYNC,
  input  logic [3:0] VD_SYNC,
  output logic       VINFO_VALID,
  output logic       VINFO_PAL,
  output logic       VINFO_INTERLACED,
  output logic       FIELD_ID,
  output logic [9:0] LINES_PER_FIELD,
  output logic       VS_STROBE
);

  localparam int VS_BIT = 3;
  localparam int HS_BIT = 1;
  localparam logic [9:0] LINE_MAX = 10'h3FF;

  typedef enum logic [1:0] {
    ST_NOSYNC,
    ST_ACQ1,
    ST_ACQ2,
    ST_LOCKED
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  sync_cur_q, sync_cur_d;
  logic [3:0]  sync_prev_q, sync_prev_d;
  logic        strobe_q, strobe_d;
  logic        evt_q, evt_d;
  logic        vs_fall_q, vs_fall_d;
  logic        hs_fall_q, hs_fall_d;
  logic [11:0] h_cnt_q, h_cnt_d;
  logic [9:0]  line_cnt_q, line_cnt_d;
  logic [9:0]  meas_q, meas_d;
  logic        cand_pal_q, cand_pal_d;
  logic        cand_il_q, cand_il_d;
  logic        valid_q, valid_d;
  logic        pal_q, pal_d;
  logic        il_q, il_d;
  logic        fid_q, fid_d;
  logic [9:0]  lpf_q, lpf_d;
  logic        vs_strobe_q, vs_strobe_d;

  logic [9:0]  m, p, diff;
  logic        pal_c, il_c, il_next, timeout;

  // CS and CLAMP are captured with the nibble but play no part in the measurement.
  logic unused_sync;
  assign unused_sync = ^{sync_prev_q[2], sync_prev_q[0]};

  always_comb begin
    // NOTE: every signal written here is given a default first, so no path
    // through the block can leave a value unassigned and infer a latch.
    state_d     = state_q;
    sync_cur_d  = sync_cur_q;
    sync_prev_d = sync_prev_q;
    h_cnt_d     = h_cnt_q;
    line_cnt_d  = line_cnt_q;
    meas_d      = meas_q;
    cand_pal_d  = cand_pal_q;
    cand_il_d   = cand_il_q;
    valid_d     = valid_q;
    pal_d       = pal_q;
    il_d        = il_q;
    fid_d       = fid_q;
    lpf_d       = lpf_q;
    il_next     = il_q;
    timeout     = 1'b0;

    // Stage 0: capture on strobe. Stage 1: detect edges one VCLK later.
    if (!nVDSYNC) begin
      sync_cur_d  = VD_SYNC;
      sync_prev_d = sync_cur_q;
    end
    strobe_d    = !nVDSYNC;
    evt_d       = strobe_q;
    vs_fall_d   = strobe_q & sync_prev_q[VS_BIT] & ~sync_cur_q[VS_BIT];
    hs_fall_d   = strobe_q & sync_prev_q[HS_BIT] & ~sync_cur_q[HS_BIT];
    vs_strobe_d = vs_fall_q;

    m     = line_cnt_q;
    p     = meas_q;
    diff  = (m > p) ? (m - p) : (p - m);
    pal_c = (m > PAL_LINE_THRES);
    il_c  = (diff == 10'd1);

    // Stage 2: counters, FSM and outputs, once per strobe.
    if (evt_q) begin
      if (hs_fall_q)              h_cnt_d = '0;
      else if (h_cnt_q < H_TIMEOUT) h_cnt_d = h_cnt_q + 12'd1;

      if (hs_fall_q && line_cnt_q != LINE_MAX) line_cnt_d = line_cnt_q + 10'd1;

      if (vs_fall_q) begin
        meas_d     = m;
        line_cnt_d = {9'd0, hs_fall_q};
        unique case (state_q)
          ST_NOSYNC: state_d = ST_ACQ1;
          ST_ACQ1:   state_d = ST_ACQ2;
          ST_ACQ2: begin
            state_d = ST_LOCKED;
            valid_d = 1'b1;
            pal_d   = pal_c;
            il_next = il_c;
            il_d    = il_c;
            lpf_d   = m;
            fid_d   = il_c & (m < p);
          end
          ST_LOCKED: begin
            // A classification bit only changes after two agreeing fields.
            if (pal_c == cand_pal_q) pal_d = pal_c;
            if (il_c == cand_il_q)   il_next = il_c;
            il_d  = il_next;
            lpf_d = m;
            fid_d = il_next & (m < p);
          end
          default: state_d = ST_NOSYNC;
        endcase
        cand_pal_d = pal_c;
        cand_il_d  = il_c;
      end

      timeout = (h_cnt_d >= H_TIMEOUT) || (line_cnt_d == LINE_MAX);
      if (timeout) begin
        state_d = ST_NOSYNC;
        valid_d = 1'b0;
        pal_d   = 1'b0;
        il_d    = 1'b0;
        fid_d   = 1'b0;
      end
    end
  end

  // NOTE: every flop here is a control/status register, so all of them take the
  // async reset; none of this is memory that could be left unreset.
  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      state_q     <= ST_NOSYNC;
      sync_cur_q  <= 4'hF;
      sync_prev_q <= 4'hF;
      strobe_q    <= 1'b0;
      evt_q       <= 1'b0;
      vs_fall_q   <= 1'b0;
      hs_fall_q   <= 1'b0;
      h_cnt_q     <= '0;
      line_cnt_q  <= '0;
      meas_q      <= '0;
      cand_pal_q  <= 1'b0;
      cand_il_q   <= 1'b0;
      valid_q     <= 1'b0;
      pal_q       <= 1'b0;
      il_q        <= 1'b0;
      fid_q       <= 1'b0;
      lpf_q       <= '0;
      vs_strobe_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      sync_cur_q  <= sync_cur_d;
      sync_prev_q <= sync_prev_d;
      strobe_q    <= strobe_d;
      evt_q       <= evt_d;
      vs_fall_q   <= vs_fall_d;
      hs_fall_q   <= hs_fall_d;
      h_cnt_q     <= h_cnt_d;
      line_cnt_q  <= line_cnt_d;
      meas_q      <= meas_d;
      cand_pal_q  <= cand_pal_d;
      cand_il_q   <= cand_il_d;
      valid_q     <= valid_d;
      pal_q       <= pal_d;
      il_q        <= il_d;
      fid_q       <= fid_d;
      lpf_q       <= lpf_d;
      vs_strobe_q <= vs_strobe_d;
    end
  end

  assign VINFO_VALID      = valid_q;
  assign VINFO_PAL        = pal_q;
  assign VINFO_INTERLACED = il_q;
  assign FIELD_ID         = fid_q;
  assign LINES_PER_FIELD  = lpf_q;
  assign VS_STROBE        = vs_strobe_q;

endmodule

// File: tb/tb_n64_vtiming_analyzer.sv
// Self-checking bench for n64_vtiming_analyzer: directed field table, hand-built
// timeout/reset/latency sequences, and random fields against a field-level model.
module tb_n64_vtiming_analyzer;

  logic       VCLK = 1'b0;
  logic       nVRST;
  logic       nVDSYNC;
  logic [3:0] VD_SYNC;
  logic       VINFO_VALID, VINFO_PAL, VINFO_INTERLACED, FIELD_ID, VS_STROBE;
  logic [9:0] LINES_PER_FIELD;

  n64_vtiming_analyzer #(
    .PAL_LINE_THRES (10'd288),
    .H_TIMEOUT      (12'd4095)
  ) dut (
    .VCLK             (VCLK),
    .nVRST            (nVRST),
    .nVDSYNC          (nVDSYNC),
    .VD_SYNC          (VD_SYNC),
    .VINFO_VALID      (VINFO_VALID),
    .VINFO_PAL        (VINFO_PAL),
    .VINFO_INTERLACED (VINFO_INTERLACED),
    .FIELD_ID         (FIELD_ID),
    .LINES_PER_FIELD  (LINES_PER_FIELD),
    .VS_STROBE        (VS_STROBE)
  );

  always #5 VCLK = ~VCLK;

  // {VS, CS, HS, CLAMP}, active-low
  localparam logic [3:0] VD_VSHS = 4'b0101;
  localparam logic [3:0] VD_VS   = 4'b0111;
  localparam logic [3:0] VD_IDLE = 4'b1111;

  int n_cmp = 0;
  int n_err = 0;
  int n_marks = 0;
  int vs_pulses = 0;
  int wide_cnt = 0;
  logic last_vs = 1'b0;

  always @(negedge VCLK) begin
    if (VS_STROBE === 1'b1) vs_pulses++;
    if (VS_STROBE === 1'b1 && last_vs === 1'b1) wide_cnt++;
    last_vs = VS_STROBE;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input bit v, input bit pal, input bit il,
                               input bit fid, input int lpf);
    check({tag, ".valid"}, 32'(VINFO_VALID), 32'(v));
    check({tag, ".pal"},   32'(VINFO_PAL), 32'(pal));
    check({tag, ".il"},    32'(VINFO_INTERLACED), 32'(il));
    check({tag, ".fid"},   32'(FIELD_ID), 32'(fid));
    check({tag, ".lpf"},   32'(LINES_PER_FIELD), 32'(lpf));
  endtask

  task automatic strobe(input logic [3:0] vd, input int gap);
    @(negedge VCLK);
    nVDSYNC = 1'b0;
    VD_SYNC = vd;
    for (int i = 1; i < gap; i++) begin
      @(negedge VCLK);
      nVDSYNC = 1'b1;
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge VCLK);
      nVDSYNC = 1'b1;
    end
  endtask

  // First strobe of a field: VS and HS fall together; outputs settle before return.
  task automatic vs_mark(input int gap);
    strobe(VD_VSHS, gap);
    idle(4);
    n_marks++;
  endtask

  // Remainder of a field of n lines (VS low for lines 1..3, HS low on each line's first strobe).
  task automatic field_rest(input int n, input int gap, input int spl);
    for (int line = 1; line <= n; line++) begin
      for (int s = 0; s < spl; s++) begin
        if (!(line == 1 && s == 0)) begin
          strobe({(line <= 3) ? 1'b0 : 1'b1, 1'b1, (s == 0) ? 1'b0 : 1'b1, 1'b1}, gap);
        end
      end
    end
  endtask

  task automatic do_reset();
    nVRST   = 1'b0;
    nVDSYNC = 1'b1;
    VD_SYNC = VD_IDLE;
    idle(3);
    nVRST = 1'b1;
    idle(1);
  endtask

  // Field-level reference model.
  int m_falls, m_p, e_lpf;
  bit m_cpal, m_cil, e_v, e_pal, e_il, e_fid;

  task automatic model_reset();
    m_falls = 0; m_p = 0; e_lpf = 0;
    m_cpal = 0; m_cil = 0; e_v = 0; e_pal = 0; e_il = 0; e_fid = 0;
  endtask

  task automatic model_fall(input int m);
    bit pc, ic;
    m_falls++;
    if (m_falls >= 3) begin
      pc = (m > 288);
      ic = (m - m_p == 1) || (m_p - m == 1);
      if (m_falls == 3) begin
        e_v = 1; e_pal = pc; e_il = ic;
      end else begin
        if (pc == m_cpal) e_pal = pc;
        if (ic == m_cil)  e_il = ic;
      end
      m_cpal = pc;
      m_cil  = ic;
      e_lpf  = m;
      e_fid  = e_il && (m < m_p);
    end
    m_p = m;
  endtask

  typedef struct {
    bit rst;
    int lines;
    int gap;
    bit v, pal, il, fid;
    int lpf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rst, input int lines, input int gap, input bit v,
                     input bit pal, input bit il, input bit fid, input int lpf);
    vec_t r;
    r.rst = rst; r.lines = lines; r.gap = gap;
    r.v = v; r.pal = pal; r.il = il; r.fid = fid; r.lpf = lpf;
    tbl.push_back(r);
  endtask

  initial begin
    // NTSC progressive
    add(1, 263, 2, 0, 0, 0, 0, 0);
    add(0, 263, 2, 1, 0, 0, 0, 263);
    add(0, 263, 2, 1, 0, 0, 0, 263);
    // NTSC interlaced, continuous strobes
    add(1, 262, 1, 0, 0, 0, 0, 0);
    add(0, 263, 1, 1, 0, 1, 0, 263);
    add(0, 262, 1, 1, 0, 1, 1, 262);
    add(0, 263, 1, 1, 0, 1, 0, 263);
    add(0, 262, 1, 1, 0, 1, 1, 262);
    // PAL interlaced
    add(1, 312, 2, 0, 0, 0, 0, 0);
    add(0, 313, 2, 1, 1, 1, 0, 313);
    add(0, 312, 2, 1, 1, 1, 1, 312);
    add(0, 313, 2, 1, 1, 1, 0, 313);
    // Locked NTSC with one 300-line field
    add(1, 263, 1, 0, 0, 0, 0, 0);
    add(0, 263, 1, 1, 0, 0, 0, 263);
    add(0, 300, 1, 1, 0, 0, 0, 300);
    add(0, 263, 1, 1, 0, 0, 0, 263);
    add(0, 263, 1, 1, 0, 0, 0, 263);

    nVRST   = 1'b0;
    nVDSYNC = 1'b1;
    VD_SYNC = VD_IDLE;
    #1;
    check_outputs("reset_async", 0, 0, 0, 0, 0);
    check("reset_async.vs_strobe", 32'(VS_STROBE), 32'd0);
    do_reset();
    check_outputs("reset", 0, 0, 0, 0, 0);
    check("reset.vs_strobe", 32'(VS_STROBE), 32'd0);

    vs_pulses = 0;
    n_marks   = 0;
    foreach (tbl[i]) begin
      if (tbl[i].rst) begin
        do_reset();
        vs_mark(tbl[i].gap);
      end
      field_rest(tbl[i].lines, tbl[i].gap, 2);
      vs_mark(tbl[i].gap);
      check_outputs($sformatf("vec%0d", i), tbl[i].v, tbl[i].pal, tbl[i].il,
                    tbl[i].fid, tbl[i].lpf);
    end
    check("vs_strobe_count", 32'(vs_pulses), 32'(n_marks));

    // HS held high while locked: 4094 strobes keep lock, the 4095th drops it.
    repeat (4094) strobe(VD_IDLE, 1);
    idle(4);
    check("pre_timeout.valid", 32'(VINFO_VALID), 32'd1);
    strobe(VD_IDLE, 1);
    idle(4);
    check_outputs("timeout", 0, 0, 0, 0, 263);

    // VS_STROBE latency and width with nVDSYNC held low; also the first relock VS fall.
    @(negedge VCLK);
    nVDSYNC = 1'b0;
    VD_SYNC = VD_VSHS;
    @(negedge VCLK);
    VD_SYNC = VD_VS;
    check("lat_n", 32'(VS_STROBE), 32'd0);
    @(negedge VCLK);
    check("lat_n1", 32'(VS_STROBE), 32'd0);
    @(negedge VCLK);
    check("lat_n2", 32'(VS_STROBE), 32'd1);
    @(negedge VCLK);
    check("lat_n3", 32'(VS_STROBE), 32'd0);
    nVDSYNC = 1'b1;
    check("relock1.valid", 32'(VINFO_VALID), 32'd0);
    field_rest(263, 1, 2);
    vs_mark(1);
    check("relock2.valid", 32'(VINFO_VALID), 32'd0);
    field_rest(263, 1, 2);
    vs_mark(1);
    check_outputs("relock3", 1, 0, 0, 0, 263);

    // Async reset mid-field while locked.
    field_rest(100, 2, 2);
    idle(1);
    @(posedge VCLK);
    #2;
    nVRST = 1'b0;
    #1;
    check_outputs("midreset", 0, 0, 0, 0, 0);
    @(negedge VCLK);
    nVRST = 1'b1;
    vs_mark(2);
    check("post_rst1.valid", 32'(VINFO_VALID), 32'd0);
    field_rest(263, 2, 2);
    vs_mark(2);
    check_outputs("post_rst2", 0, 0, 0, 0, 0);
    field_rest(263, 2, 2);
    vs_mark(2);
    check_outputs("post_rst3", 1, 0, 0, 0, 263);

    // Random fields against the model.
    do_reset();
    model_reset();
    vs_mark(1);
    model_fall(0);
    for (int k = 0; k < 14; k++) begin
      int n, gap, spl;
      case ($urandom_range(0, 3))
        0:       n = $urandom_range(250, 330);
        1:       n = 288 + $urandom_range(0, 1);
        2:       n = 262 + $urandom_range(0, 1);
        default: n = 312 + $urandom_range(0, 1);
      endcase
      gap = $urandom_range(1, 2);
      spl = $urandom_range(2, 3);
      field_rest(n, gap, spl);
      vs_mark(gap);
      model_fall(n);
      check_outputs($sformatf("rnd%0d_n%0d", k, n), e_v, e_pal, e_il, e_fid, e_lpf);
    end

    check("vs_strobe_width", 32'(wide_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
